// File: rtl/lbp_img_server.sv
// Host-side peer of the LBP engine: loads a gray image, serves engine reads,
// captures LBP results and streams the result image back out in raster order.
module lbp_img_server #(
    parameter int unsigned AW    = 14,
    parameter int unsigned DW    = 8,
    parameter int unsigned IMG_W = 128
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          gray_ready,
    input  logic          gray_req,
    input  logic [AW-1:0] gray_addr,
    output logic [DW-1:0] gray_data,
    input  logic          lbp_valid,
    input  logic [AW-1:0] lbp_addr,
    input  logic [DW-1:0] lbp_data,
    input  logic          finish,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    output logic          done,
    output logic [AW-1:0] wr_cnt,
    output logic [2:0]    err
);

    localparam int unsigned Depth = 2 ** AW;
    localparam int unsigned ColW  = $clog2(IMG_W);
    localparam int unsigned RowW  = AW - ColW;

    localparam logic [ColW-1:0] ColMax      = ColW'(IMG_W - 1);
    localparam logic [RowW-1:0] RowMax      = RowW'(IMG_W - 1);
    localparam logic [AW-1:0]   InteriorCnt = AW'((IMG_W - 2) * (IMG_W - 2));

    typedef enum logic [1:0] {StLoad, StServe, StDrain, StDone} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] ld_cnt_q, ld_cnt_d;
    logic [AW-1:0] out_addr_q, out_addr_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [2:0]    err_q, err_d;

    logic [DW-1:0] gray_mem [Depth];
    logic [DW-1:0] lbp_mem  [Depth];

    logic gray_we;
    logic lbp_we;

    function automatic logic is_border(input logic [AW-1:0] a);
        logic [ColW-1:0] col;
        logic [RowW-1:0] row;
        col = a[ColW-1:0];
        row = a[AW-1:ColW];
        return (col == '0) || (col == ColMax) || (row == '0) || (row == RowMax);
    endfunction

    always_comb begin
        state_d    = state_q;
        ld_cnt_d   = ld_cnt_q;
        out_addr_d = out_addr_q;
        wr_cnt_d   = wr_cnt_q;
        err_d      = err_q;
        gray_we    = 1'b0;
        lbp_we     = 1'b0;

        unique case (state_q)
            StLoad: begin
                if (gray_req) err_d[0] = 1'b1;
                if (ld_valid) begin
                    gray_we  = 1'b1;
                    ld_cnt_d = ld_cnt_q + 1'b1;
                    if (ld_cnt_q == '1) state_d = StServe;
                end
            end
            StServe: begin
                if (lbp_valid) begin
                    if (is_border(lbp_addr)) begin
                        err_d[1] = 1'b1;
                    end else begin
                        lbp_we = 1'b1;
                        if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
                // Count check includes a write landing in the finish cycle.
                if (finish) begin
                    state_d = StDrain;
                    if (wr_cnt_d != InteriorCnt) err_d[2] = 1'b1;
                end
            end
            StDrain: begin
                if (out_ready) begin
                    out_addr_d = out_addr_q + 1'b1;
                    if (out_addr_q == '1) state_d = StDone;
                end
            end
            StDone: ;
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StLoad;
            ld_cnt_q   <= '0;
            out_addr_q <= '0;
            wr_cnt_q   <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            out_addr_q <= out_addr_d;
            wr_cnt_q   <= wr_cnt_d;
            err_q      <= err_d;
        end
    end

    // Memory contents survive reset; the image is always fully reloaded.
    always_ff @(posedge clk) begin
        if (gray_we) gray_mem[ld_cnt_q] <= ld_data;
        if (lbp_we)  lbp_mem[lbp_addr]  <= lbp_data;
    end

    always_comb begin
        gray_ready = (state_q == StServe);
        out_valid  = (state_q == StDrain);
        done       = (state_q == StDone);
        out_addr   = out_addr_q;
        wr_cnt     = wr_cnt_q;
        err        = err_q;
        gray_data  = (gray_ready && gray_req) ? gray_mem[gray_addr] : '0;
        out_data   = (out_valid && !is_border(out_addr_q)) ? lbp_mem[out_addr_q] : '0;
    end

endmodule
